scr1_div_seq: RTL and testbench

SCR1_DIV_SEQ -- requirements
Module: scr1_div_seq

---
 rtl/scr1_div_seq.sv | 172 +++++++++++++++++
 tb/tb_scr1_div_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_div_seq.sv
// scr1_div_seq: sequential radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One quotient bit per cycle; signed operations run on magnitudes with a final
// sign-correction cycle. Divide-by-zero and signed overflow skip the iterations.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   div_req   - start request, sampled only while idle
//   div_op    - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   div_op1   - dividend (rs1)
//   div_op2   - divisor (rs2)
//   div_kill  - abort the operation in progress
//   div_busy  - high while not idle
//   div_rdy   - one-cycle pulse when div_res is valid
//   div_res   - quotient or remainder, held until the next completion
module scr1_div_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_req,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] div_op1,
    input  logic [XLEN-1:0] div_op2,
    input  logic            div_kill,
    output logic            div_busy,
    output logic            div_rdy,
    output logic [XLEN-1:0] div_res
);

    localparam int unsigned     CNT_W   = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              accept;

    logic [1:0]        op_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   dvsr_q;
    logic              quo_neg_q;
    logic              rem_neg_q;
    logic [CNT_W-1:0]  cnt_q;

    // Operand classification at accept time
    logic              is_signed;
    logic              div_zero;
    logic              ovf;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;

    assign is_signed = ~div_op[0];
    assign div_zero  = (div_op2 == '0);
    assign ovf       = is_signed && (div_op1 == MIN_NEG) && (div_op2 == '1);
    assign mag1      = (is_signed && div_op1[XLEN-1]) ? (~div_op1 + XLEN'(1)) : div_op1;
    assign mag2      = (is_signed && div_op2[XLEN-1]) ? (~div_op2 + XLEN'(1)) : div_op2;

    // One restoring step: shift {rem,quo} left and trial-subtract the divisor.
    // rem < divisor always holds, so the shifted value fits in XLEN+1 bits and
    // the MSB of the difference is a clean borrow flag.
    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;

    assign trial    = {rem_q, quo_q[XLEN-1]};
    assign diff     = trial - {1'b0, dvsr_q};
    assign rem_step = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};

    // Sign correction and result select
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   res_sel;

    assign quo_fix = quo_neg_q ? (~quo_q + XLEN'(1)) : quo_q;
    assign rem_fix = rem_neg_q ? (~rem_q + XLEN'(1)) : rem_q;
    assign res_sel = op_q[1] ? rem_fix : quo_fix;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; special cases take a single cycle through CORR to form the result
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (div_req && !div_kill) begin
                    accept  = 1'b1;
                    state_d = (div_zero || ovf) ? CORR : CALC;
                end
            end
            CALC: begin
                if (div_kill) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = CORR;
                end
            end
            CORR:    state_d = div_kill ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= 2'b00;
            quo_q     <= '0;
            rem_q     <= '0;
            dvsr_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            div_busy  <= 1'b0;
            div_rdy   <= 1'b0;
            div_res   <= '0;
        end else begin
            if (accept) begin
                op_q   <= div_op;
                dvsr_q <= mag2;
                if (div_zero) begin
                    quo_q     <= '1;
                    rem_q     <= div_op1;
                    quo_neg_q <= 1'b0;
                    rem_neg_q <= 1'b0;
                    cnt_q     <= '0;
                end else if (ovf) begin
                    quo_q     <= MIN_NEG;
                    rem_q     <= '0;
                    quo_neg_q <= 1'b0;
                    rem_neg_q <= 1'b0;
                    cnt_q     <= '0;
                end else begin
                    quo_q     <= mag1;
                    rem_q     <= '0;
                    quo_neg_q <= is_signed && (div_op1[XLEN-1] ^ div_op2[XLEN-1]);
                    rem_neg_q <= is_signed && div_op1[XLEN-1];
                    cnt_q     <= CNT_W'(XLEN - 1);
                end
            end else if ((state_q == CALC) && !div_kill) begin
                quo_q <= quo_step;
                rem_q <= rem_step;
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if ((state_q == CORR) && !div_kill) begin
                div_res <= res_sel;
            end

            div_busy <= (state_d != IDLE);
            div_rdy  <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_scr1_div_seq.sv
// tb_scr1_div_seq: directed-vector bench for scr1_div_seq (XLEN=32).
// A transaction-level reference model (arithmetic result plus fixed latency)
// is compared against busy/rdy/res every cycle; each directed operation also
// checks a hand-computed result and latency.
module tb_scr1_div_seq;

    localparam int unsigned XLEN = 32;
    localparam int          NORM_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            div_req = 1'b0;
    logic [1:0]      div_op = 2'b00;
    logic [XLEN-1:0] div_op1 = '0;
    logic [XLEN-1:0] div_op2 = '0;
    logic            div_kill = 1'b0;
    logic            div_busy;
    logic            div_rdy;
    logic [XLEN-1:0] div_res;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_res = 32'h0;

    scr1_div_seq #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .div_req  (div_req),
        .div_op   (div_op),
        .div_op1  (div_op1),
        .div_op2  (div_op2),
        .div_kill (div_kill),
        .div_busy (div_busy),
        .div_rdy  (div_rdy),
        .div_res  (div_res)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of a RISC-V divide/remainder
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            sa = $signed(a);
            sb = $signed(b);
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NORM_LAT;
    endfunction

    // Reference model: edges since accept, result published at the latency edge
    bit          m_busy = 1'b0;
    bit          m_rdy  = 1'b0;
    logic [31:0] m_res  = 32'h0;
    logic [31:0] m_pend = 32'h0;
    int          m_e    = 0;
    int          m_lat  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_rdy  = 1'b0;
            m_res  = 32'h0;
            m_e    = 0;
        end else begin
            m_rdy = 1'b0;
            if (!m_busy) begin
                if (div_req && !div_kill) begin
                    m_busy = 1'b1;
                    m_e    = 0;
                    m_lat  = ref_lat(div_op, div_op1, div_op2);
                    m_pend = ref_res(div_op, div_op1, div_op2);
                end
            end else if (div_kill) begin
                m_busy = 1'b0;
            end else begin
                m_e++;
                if (m_e == m_lat) begin
                    m_rdy = 1'b1;
                    m_res = m_pend;
                end else if (m_e == m_lat + 1) begin
                    m_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(div_busy), 32'(m_busy));
        check("rdy", 32'(div_rdy), 32'(m_rdy));
        check("res", div_res, m_res);
    end

    // Hold req until accepted; afterwards scramble the operand inputs
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit hold);
        int n;
        div_op  = op;
        div_op1 = a;
        div_op2 = b;
        div_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!div_busy && n < 100);
        if (!div_busy) check("accept_timeout", 32'(div_busy), 32'h1);
        div_op  = ~op;
        div_op1 = ~a;
        div_op2 = b ^ 32'h5A5A_5A5A;
        div_req = hold;
    endtask

    task automatic finish_op(input string name, input logic [31:0] exp, input int exp_lat);
        int k;
        k = 0;
        while (!div_rdy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 3) div_req = 1'b0;
        end
        div_req = 1'b0;
        check({name, "_res"}, div_res, exp);
        check({name, "_lat"}, 32'(k), 32'(exp_lat));
        last_res = exp;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        start_op(op, a, b, exp_lat > 3);
        finish_op(name, exp, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(div_busy), 32'h0);
        check("rst_rdy", 32'(div_rdy), 32'h0);
        check("rst_res", div_res, 32'h0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back: each op is requested while the previous sits in DONE
        run_op("div_20_m3",     2'b00, 32'd20,         32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
        run_op("rem_m20_3",     2'b10, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33);
        run_op("remu_max_2",    2'b11, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 33);
        run_op("divu_max_2",    2'b01, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 33);
        run_op("div_7_0",       2'b00, 32'd7,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_7_0",       2'b10, 32'd7,          32'd0,         32'h0000_0007, 1);
        run_op("divu_7_0",      2'b01, 32'd7,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_m7_0",      2'b10, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1);
        run_op("div_ovf",       2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",       2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("divu_ovf_ops",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("div_m100_7",    2'b00, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 33);
        run_op("rem_m100_7",    2'b10, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 33);
        run_op("div_m100_m7",   2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'h0000_000E, 33);
        run_op("rem_100_m7",    2'b10, 32'd100,        32'hFFFF_FFF9, 32'h0000_0002, 33);
        run_op("divu_5_9",      2'b01, 32'd5,          32'd9,         32'h0000_0000, 33);
        run_op("remu_5_9",      2'b11, 32'd5,          32'd9,         32'h0000_0005, 33);
        run_op("remu_ovf_ops",  2'b11, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33);

        // Kill sampled on edge 10 of a DIV
        start_op(2'b00, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1 div_kill = 1'b1;
        @(posedge clk);
        #1;
        div_kill = 1'b0;
        check("kill_busy", 32'(div_busy), 32'h0);
        check("kill_rdy", 32'(div_rdy), 32'h0);
        check("kill_res", div_res, last_res);
        @(posedge clk);
        #1;
        check("kill_busy_e11", 32'(div_busy), 32'h0);
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000_000E, 33);

        // req together with kill in IDLE does not start
        @(posedge clk);
        #1;
        div_req  = 1'b1;
        div_kill = 1'b1;
        div_op   = 2'b01;
        div_op1  = 32'd9;
        div_op2  = 32'd3;
        @(posedge clk);
        #1;
        check("reqkill_busy", 32'(div_busy), 32'h0);
        div_req  = 1'b0;
        div_kill = 1'b0;

        // Asynchronous reset in the middle of a REM
        start_op(2'b10, 32'd1234, 32'd7, 1'b0);
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(div_busy), 32'h0);
        check("arst_rdy", 32'(div_rdy), 32'h0);
        check("arst_res", div_res, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_op("rem_100_7", 2'b10, 32'd100, 32'd7, 32'h0000_0002, 33);

        repeat (3) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
